trainer: RTL and testbench

TRAINER -- requirements
Module: trainer

---
 rtl/trainer_pkg.sv | 29 ++
 rtl/trainer.sv | 161 ++++++++++++++++
 tb/tb_trainer.sv | 376 +++++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/trainer_pkg.sv
// Shared types for the trainer: operand/error widths, FSM states,
// and the error/magnitude helpers used by the top.
package trainer_pkg;

  typedef logic [7:0] operand_t;
  typedef logic signed [15:0] error_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SEND,
    S_WAIT,
    S_ERR,
    S_DRAIN,
    S_REPORT
  } state_e;

  function automatic error_t calc_error(operand_t tgt, operand_t out);
    logic [8:0] d;
    d = {1'b0, tgt} - {1'b0, out};
    return error_t'({{7{d[8]}}, d});
  endfunction

  function automatic logic [15:0] err_mag(error_t e);
    logic [15:0] m;
    m = e[15] ? 16'(-e) : 16'(e);
    return m;
  endfunction

endpackage

// File: rtl/trainer.sv
// Sample sequencer for an external node: forward, error, backward drain.
// Optional loss accumulation is enabled by defining TRAINER_LOSS_EN.
module trainer
  import trainer_pkg::*;
#(
  parameter int N     = 2,
  parameter int EPOCH = 4
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              train,
  input  logic              sample_valid,
  input  logic [N*8-1:0]    sample_data,
  input  logic [7:0]        sample_target,
  output logic              sample_ready,
  output logic              node_train,
  output logic              node_fwd_valid,
  output logic [N*8-1:0]    node_fwd_data,
  input  logic              node_fwd_ready,
  input  logic              node_out_valid,
  input  logic [7:0]        node_out_data,
  output logic              node_out_ready,
  output logic              node_err_valid,
  output logic [15:0]       node_err_data,
  input  logic              node_err_ready,
  input  logic              node_bwd_valid,
  input  logic [N*16-1:0]   node_bwd_data,
  output logic              node_bwd_ready,
  output logic              result_valid,
  output logic [7:0]        result_data,
  output logic [15:0]       result_error,
  input  logic              result_ready,
  output logic [15:0]       epoch_count
`ifdef TRAINER_LOSS_EN
 ,output logic [31:0]       loss_sum,
  output logic [31:0]       loss_epoch
`endif
);

  localparam int CW = (EPOCH > 1) ? $clog2(EPOCH) : 1;
  localparam logic [CW-1:0] LAST = CW'(EPOCH - 1);

  state_e           state_q, state_d;
  logic [N*8-1:0]   data_q, data_d;
  operand_t         target_q, target_d;
  logic             train_q, train_d;
  operand_t         out_q, out_d;
  error_t           err_q, err_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [15:0]      epoch_q, epoch_d;
`ifdef TRAINER_LOSS_EN
  logic [31:0]      lsum_q, lsum_d;
  logic [31:0]      lep_q, lep_d;
`endif

  // Backward gradients are consumed and dropped.
  logic unused_bwd;
  assign unused_bwd = ^node_bwd_data;

  // Handshake signals are pure decodes of the state register.
  assign sample_ready   = (state_q == S_IDLE);
  assign node_fwd_valid = (state_q == S_SEND);
  assign node_out_ready = (state_q == S_WAIT);
  assign node_err_valid = (state_q == S_ERR);
  assign node_bwd_ready = (state_q == S_DRAIN);
  assign result_valid   = (state_q == S_REPORT);
  assign node_train     = train_q & ((state_q == S_SEND) |
                                     (state_q == S_WAIT) |
                                     (state_q == S_ERR)  |
                                     (state_q == S_DRAIN));
  assign node_fwd_data  = data_q;
  assign node_err_data  = err_q;
  assign result_data    = out_q;
  assign result_error   = err_q;
  assign epoch_count    = epoch_q;
`ifdef TRAINER_LOSS_EN
  assign loss_sum       = lsum_q;
  assign loss_epoch     = lep_q;
`endif

  // Next-state, capture and counter logic.
  always_comb begin
    state_d  = state_q;
    data_d   = data_q;
    target_d = target_q;
    train_d  = train_q;
    out_d    = out_q;
    err_d    = err_q;
    cnt_d    = cnt_q;
    epoch_d  = epoch_q;
`ifdef TRAINER_LOSS_EN
    lsum_d   = lsum_q;
    lep_d    = lep_q;
`endif
    unique case (state_q)
      S_IDLE: if (sample_valid) begin
        data_d   = sample_data;
        target_d = sample_target;
        train_d  = train;
        state_d  = S_SEND;
      end
      S_SEND: if (node_fwd_ready) state_d = S_WAIT;
      S_WAIT: if (node_out_valid) begin
        out_d   = node_out_data;
        err_d   = calc_error(target_q, node_out_data);
        state_d = train_q ? S_ERR : S_REPORT;
      end
      S_ERR:   if (node_err_ready) state_d = S_DRAIN;
      S_DRAIN: if (node_bwd_valid) state_d = S_REPORT;
      S_REPORT: if (result_ready) begin
        state_d = S_IDLE;
        if (cnt_q == LAST) begin
          cnt_d   = '0;
          epoch_d = epoch_q + 16'd1;
`ifdef TRAINER_LOSS_EN
          lep_d   = lsum_q + {16'd0, err_mag(err_q)};
          lsum_d  = '0;
`endif
        end else begin
          cnt_d   = cnt_q + CW'(1);
`ifdef TRAINER_LOSS_EN
          lsum_d  = lsum_q + {16'd0, err_mag(err_q)};
`endif
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      data_q   <= '0;
      target_q <= '0;
      train_q  <= 1'b0;
      out_q    <= '0;
      err_q    <= '0;
      cnt_q    <= '0;
      epoch_q  <= '0;
`ifdef TRAINER_LOSS_EN
      lsum_q   <= '0;
      lep_q    <= '0;
`endif
    end else begin
      state_q  <= state_d;
      data_q   <= data_d;
      target_q <= target_d;
      train_q  <= train_d;
      out_q    <= out_d;
      err_q    <= err_d;
      cnt_q    <= cnt_d;
      epoch_q  <= epoch_d;
`ifdef TRAINER_LOSS_EN
      lsum_q   <= lsum_d;
      lep_q    <= lep_d;
`endif
    end
  end

endmodule

// File: tb/tb_trainer.sv
// Randomized scoreboard bench for trainer with a behavioural node model.
// Loss checks are compiled in when TRAINER_LOSS_EN is defined.
module tb_trainer;
  import trainer_pkg::*;

  localparam int N     = 2;
  localparam int EPOCH = 4;
  localparam int DW    = N * 8;
  localparam int BW    = N * 16;

  logic          clock = 1'b0;
  logic          reset;
  logic          train;
  logic          sample_valid;
  logic [DW-1:0] sample_data;
  logic [7:0]    sample_target;
  logic          sample_ready;
  logic          node_train;
  logic          node_fwd_valid;
  logic [DW-1:0] node_fwd_data;
  logic          node_fwd_ready;
  logic          node_out_valid;
  logic [7:0]    node_out_data;
  logic          node_out_ready;
  logic          node_err_valid;
  logic [15:0]   node_err_data;
  logic          node_err_ready;
  logic          node_bwd_valid;
  logic [BW-1:0] node_bwd_data;
  logic          node_bwd_ready;
  logic          result_valid;
  logic [7:0]    result_data;
  logic [15:0]   result_error;
  logic          result_ready;
  logic [15:0]   epoch_count;
`ifdef TRAINER_LOSS_EN
  logic [31:0]   loss_sum;
  logic [31:0]   loss_epoch;
`endif

  always #5 clock = ~clock;

  trainer #(.N(N), .EPOCH(EPOCH)) dut (
    .clock(clock), .reset(reset), .train(train),
    .sample_valid(sample_valid), .sample_data(sample_data),
    .sample_target(sample_target), .sample_ready(sample_ready),
    .node_train(node_train),
    .node_fwd_valid(node_fwd_valid), .node_fwd_data(node_fwd_data),
    .node_fwd_ready(node_fwd_ready),
    .node_out_valid(node_out_valid), .node_out_data(node_out_data),
    .node_out_ready(node_out_ready),
    .node_err_valid(node_err_valid), .node_err_data(node_err_data),
    .node_err_ready(node_err_ready),
    .node_bwd_valid(node_bwd_valid), .node_bwd_data(node_bwd_data),
    .node_bwd_ready(node_bwd_ready),
    .result_valid(result_valid), .result_data(result_data),
    .result_error(result_error), .result_ready(result_ready),
    .epoch_count(epoch_count)
`ifdef TRAINER_LOSS_EN
   ,.loss_sum(loss_sum), .loss_epoch(loss_epoch)
`endif
  );

  typedef struct {
    logic [DW-1:0] data;
    logic          tr;
    logic [7:0]    out;
    int            err;
  } txn_t;

  txn_t fwd_q[$];
  txn_t err_q[$];
  txn_t res_q[$];

  int     vectors = 0;
  int     miscompares = 0;
  int     n_res = 0;
  longint m_loss_sum = 0;
  longint m_loss_epoch = 0;

  logic       hold_fwd = 1'b0;
  logic       hold_out = 1'b0;
  logic       force_en = 1'b0;
  logic [7:0] force_val = 8'd0;

  task automatic check(string name, logic signed [63:0] act,
                       logic signed [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic fail_line(string name);
    vectors++;
    miscompares++;
    $display("FAIL %s: event missing or unexpected", name);
  endtask

  // Node transfer function: weighted operand sum, modulo 256.
  function automatic logic [7:0] node_fn(logic [DW-1:0] d);
    int s;
    s = 11;
    for (int i = 0; i < N; i++) s += int'(d[8*i +: 8]) * (2 * i + 3);
    return 8'(s);
  endfunction

  // Behavioural node and result sink with random backpressure.
  initial begin
    logic fh, oh, rh, pend;
    logic [DW-1:0] fd;
    logic [7:0] pdata;
    pend = 1'b0;
    pdata = 8'd0;
    node_fwd_ready = 1'b0;
    node_out_valid = 1'b0;
    node_out_data  = 8'd0;
    node_err_ready = 1'b0;
    node_bwd_valid = 1'b0;
    node_bwd_data  = '0;
    result_ready   = 1'b0;
    forever begin
      @(negedge clock);
      rh = reset;
      fh = node_fwd_valid && node_fwd_ready;
      oh = node_out_valid && node_out_ready;
      fd = node_fwd_data;
      @(posedge clock);
      #1;
      if (rh) pend = 1'b0;
      else begin
        if (fh) begin
          pend = 1'b1;
          pdata = force_en ? force_val : node_fn(fd);
        end
        if (oh) pend = 1'b0;
      end
      node_out_data  = pdata;
      node_out_valid = pend && !hold_out && ($urandom_range(3) != 0);
      node_fwd_ready = !hold_fwd && ($urandom_range(3) != 0);
      node_err_ready = ($urandom_range(3) != 0);
      node_bwd_valid = ($urandom_range(3) != 0);
      node_bwd_data  = BW'($urandom);
      result_ready   = ($urandom_range(3) != 0);
    end
  end

  // Monitor: pops the scoreboard whenever the DUT completes a handshake.
  initial begin
    logic stall;
    logic [DW-1:0] pdat;
    txn_t t;
    longint mag;
    stall = 1'b0;
    pdat = '0;
    forever begin
      @(negedge clock);
      if (reset) begin
        stall = 1'b0;
      end else begin
        if (stall) begin
          check("fwd_valid_held", node_fwd_valid, 1);
          check("fwd_data_held", node_fwd_data, pdat);
        end
        stall = node_fwd_valid && !node_fwd_ready;
        pdat = node_fwd_data;
        if (node_fwd_valid && node_fwd_ready) begin
          if (fwd_q.size() == 0) fail_line("fwd_unexpected");
          else begin
            t = fwd_q.pop_front();
            check("fwd_data", node_fwd_data, t.data);
            check("fwd_node_train", node_train, t.tr);
          end
        end
        if (node_err_valid && node_err_ready) begin
          if (err_q.size() == 0) fail_line("err_unexpected");
          else begin
            t = err_q.pop_front();
            check("err_data", $signed(node_err_data), t.err);
            check("err_node_train", node_train, 1);
          end
        end
        if (result_valid && result_ready) begin
          if (res_q.size() == 0) fail_line("result_unexpected");
          else begin
            t = res_q.pop_front();
            check("result_data", result_data, t.out);
            check("result_error", $signed(result_error), t.err);
            check("epoch_count", epoch_count, n_res / EPOCH);
`ifdef TRAINER_LOSS_EN
            check("loss_sum", loss_sum, m_loss_sum);
`endif
            mag = (t.err < 0) ? -t.err : t.err;
            n_res++;
            m_loss_sum += mag;
            if (n_res % EPOCH == 0) begin
              m_loss_epoch = m_loss_sum;
              m_loss_sum = 0;
            end
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    sample_valid = 1'b0;
    fwd_q.delete();
    err_q.delete();
    res_q.delete();
    n_res = 0;
    m_loss_sum = 0;
    m_loss_epoch = 0;
    tick();
    reset = 1'b0;
  endtask

  task automatic send(logic tr, logic [DW-1:0] d, logic [7:0] tg,
                      logic [7:0] exp_out);
    txn_t t;
    logic hs;
    t.data = d;
    t.tr = tr;
    t.out = exp_out;
    t.err = int'(tg) - int'(exp_out);
    fwd_q.push_back(t);
    if (tr) err_q.push_back(t);
    res_q.push_back(t);
    train = tr;
    sample_data = d;
    sample_target = tg;
    sample_valid = 1'b1;
    hs = 1'b0;
    for (int i = 0; i < 200 && !hs; i++) begin
      @(negedge clock);
      hs = sample_ready;
      tick();
    end
    sample_valid = 1'b0;
    if (!hs) fail_line("sample_accept_timeout");
  endtask

  task automatic wait_idle();
    int k;
    k = 0;
    while ((res_q.size() != 0) && (k < 1000)) begin
      tick();
      k++;
    end
    if (res_q.size() != 0) fail_line("drain_timeout");
    tick();
  endtask

  function automatic logic [DW-1:0] rand_data();
    logic [DW-1:0] d;
    for (int i = 0; i < N; i++) d[8*i +: 8] = 8'($urandom);
    return d;
  endfunction

  initial begin
    logic [DW-1:0] d;
    logic [7:0] tg;
    logic tr;
    int k;
    reset = 1'b1;
    train = 1'b0;
    sample_valid = 1'b0;
    sample_data = '0;
    sample_target = 8'd0;
    tick();
    do_reset();

    @(negedge clock);
    check("rst_sample_ready", sample_ready, 1);
    check("rst_result_valid", result_valid, 0);
    check("rst_fwd_valid", node_fwd_valid, 0);
    check("rst_err_valid", node_err_valid, 0);
    check("rst_out_ready", node_out_ready, 0);
    check("rst_bwd_ready", node_bwd_ready, 0);
    check("rst_node_train", node_train, 0);
    check("rst_epoch", epoch_count, 0);
    tick();

    force_en = 1'b1;
    force_val = 8'd150;
    send(1'b0, {8'd20, 8'd10}, 8'd200, 8'd150);
    wait_idle();
    force_val = 8'd255;
    send(1'b1, {8'd3, 8'd4}, 8'd0, 8'd255);
    wait_idle();
    force_en = 1'b0;

    hold_fwd = 1'b1;
    d = rand_data();
    send(1'b0, d, 8'd77, node_fn(d));
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      check("bp_fwd_valid", node_fwd_valid, 1);
      check("bp_fwd_data", node_fwd_data, d);
    end
    hold_fwd = 1'b0;
    wait_idle();

    for (int i = 0; i < 30; i++) begin
      d = rand_data();
      tg = 8'($urandom);
      tr = 1'($urandom_range(1));
      send(tr, d, tg, node_fn(d));
      if ($urandom_range(1) == 1) wait_idle();
    end
    wait_idle();

    hold_out = 1'b1;
    d = rand_data();
    send(1'b1, d, 8'd9, node_fn(d));
    k = 0;
    while (!node_out_ready && k < 100) begin
      @(negedge clock);
      k++;
    end
    if (!node_out_ready) fail_line("wait_state_timeout");
    tick();
    do_reset();
    hold_out = 1'b0;
    @(negedge clock);
    check("midrst_sample_ready", sample_ready, 1);
    check("midrst_result_valid", result_valid, 0);
    check("midrst_epoch", epoch_count, 0);
    tick();

    for (int i = 0; i < 8; i++) begin
      d = rand_data();
      send(1'($urandom_range(1)), d, 8'($urandom), node_fn(d));
    end
    wait_idle();
    @(negedge clock);
    check("epoch_after_8", epoch_count, 2);
    tick();

`ifdef TRAINER_LOSS_EN
    do_reset();
    tick();
    force_en = 1'b1;
    force_val = 8'd97;
    send(1'b0, rand_data(), 8'd100, 8'd97);
    wait_idle();
    force_val = 8'd105;
    send(1'b1, rand_data(), 8'd100, 8'd105);
    wait_idle();
    force_val = 8'd100;
    send(1'b0, rand_data(), 8'd100, 8'd100);
    wait_idle();
    force_val = 8'd93;
    send(1'b1, rand_data(), 8'd100, 8'd93);
    wait_idle();
    force_en = 1'b0;
    @(negedge clock);
    check("loss_epoch", loss_epoch, 15);
    check("loss_epoch_model", loss_epoch, m_loss_epoch);
    check("loss_sum_cleared", loss_sum, 0);
    tick();
`endif

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
